step_resume_ctrl: RTL

//  Responder side of the Simple-CPU pause/continue handshake. The control unit raises halt_req
//  (pause instruction); this block stalls the CPU. Resume requires a synchronised, debounced

---
 rtl/step_resume_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/step_resume_ctrl.sv
// step_resume_ctrl: responder side of the CPU pause/continue handshake.
// Stalls the CPU on a halt request and releases it with exactly one
// resume_pulse per debounced press of the continue button.
// Optional feature macro: STEP_MODE_EN (adds step_mode/instr_done single-step halting).
module step_resume_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int CNT_W           = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic continue_btn,
    input  logic halt_req,
`ifdef STEP_MODE_EN
    input  logic step_mode,
    input  logic instr_done,
`endif
    output logic cpu_stall,
    output logic resume_pulse,
    output logic halted,
    output logic btn_level
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_RESUME  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]             r_rstSync;
    logic                   w_rstN;
    logic [SYNC_STAGES-1:0] r_btnSync;
    logic                   w_btnS;
    logic [CNT_W-1:0]       r_debCnt;
    logic                   r_btnLevel;
    logic                   w_mismatch;
    logic                   w_cntDone;
    logic                   w_press;
    logic                   w_haltReq;
    state_t                 r_state;
    state_t                 w_nextState;
    logic                   r_cpuStall;
    logic                   r_resumePulse;
    logic                   r_halted;

    // Reset asserts asynchronously but releases only on a clock edge
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN = r_rstSync[1];

    // Bring the raw button level into the clock domain
    always_ff @(posedge clk_100MHz or negedge w_rstN) begin
        if (!w_rstN) begin
            r_btnSync <= '0;
        end else begin
            r_btnSync <= {r_btnSync[SYNC_STAGES-2:0], continue_btn};
        end
    end

    assign w_btnS     = r_btnSync[SYNC_STAGES-1];
    assign w_mismatch = (w_btnS != r_btnLevel);
    assign w_cntDone  = w_mismatch && (r_debCnt == CNT_MAX);
    // The press event coincides with the cycle the debounced level rises,
    // so the FSM reacts in the same edge that updates btn_level.
    assign w_press    = w_cntDone && w_btnS;

    // Debounce: the level follows the synchronised input only after it has stayed different long enough
    always_ff @(posedge clk_100MHz or negedge w_rstN) begin
        if (!w_rstN) begin
            r_debCnt   <= '0;
            r_btnLevel <= 1'b0;
        end else if (!w_mismatch) begin
            r_debCnt   <= '0;
        end else if (w_cntDone) begin
            r_debCnt   <= '0;
            r_btnLevel <= w_btnS;
        end else begin
            r_debCnt   <= r_debCnt + CNT_ONE;
        end
    end

`ifdef STEP_MODE_EN
    assign w_haltReq = halt_req || (step_mode && instr_done);
`else
    assign w_haltReq = halt_req;
`endif

    // Next-state logic: halt wins over a press in RUN; only a fresh press leaves HALTED
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_haltReq) begin
                    w_nextState = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (w_press) begin
                    w_nextState = ST_RESUME;
                end
            end
            ST_RESUME: begin
                w_nextState = ST_RUN;
            end
            default: begin
                w_nextState = ST_RUN;
            end
        endcase
    end

    // State and outputs are registered together so outputs are glitch-free decodes of the next state
    always_ff @(posedge clk_100MHz or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state       <= ST_RUN;
            r_cpuStall    <= 1'b0;
            r_resumePulse <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_cpuStall    <= (w_nextState == ST_HALTED);
            r_resumePulse <= (w_nextState == ST_RESUME);
            r_halted      <= (w_nextState == ST_HALTED);
        end
    end

    assign cpu_stall    = r_cpuStall;
    assign resume_pulse = r_resumePulse;
    assign halted       = r_halted;
    assign btn_level    = r_btnLevel;

endmodule
